nibble_serial_alu_ctrl: RTL and testbench

Sequencer that performs wide add/subtract by time-multiplexing the existing 4-bit arithmeticUnit, one nibble per clock, LSB first. It chains carry or borrow between nibbles and drives the unit's opCode gating. It accumulates the wide result and reports carry/borrow and signed overflow to the requester over a start/done handshake. The arithmeticUnit instance sits outside this block and connects through the au_* ports.

---
 rtl/nibble_serial_alu_ctrl.sv | 168 ++++++++++++++++
 tb/tb_nibble_serial_alu_ctrl.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/nibble_serial_alu_ctrl.sv
// nibble_serial_alu_ctrl: wide add/subtract sequencer that time-multiplexes
// an external 4-bit arithmeticUnit (au_* ports), one nibble per clock, LSB
// first, chaining carry/borrow between nibbles.
// Optional build macro ZERO_FLAG_EN adds a registered 'zero' result flag.
// DONE spans two cycles: the first arms the done flop, and the second is the
// cycle in which done is high. Starts in either cycle are dropped.
module nibble_serial_alu_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   op,
  input  logic [4*NIBBLES-1:0]   a_in,
  input  logic [4*NIBBLES-1:0]   b_in,
  input  logic                   carry_in,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   result,
  output logic                   carry_out,
  output logic                   overflow,
`ifdef ZERO_FLAG_EN
  output logic                   zero,
`endif
  output logic [1:0]             au_opCode,
  output logic [3:0]             au_A,
  output logic [3:0]             au_B,
  output logic                   au_CarryIN,
  input  logic [3:0]             au_add_Y,
  input  logic [3:0]             au_sub_Y,
  input  logic                   au_CarryOUT
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          chain_q, chain_d;
  logic          op_q, op_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d;
  logic [W-1:0]  result_q, result_d;
  logic          carry_out_q, carry_out_d;
  logic          overflow_q, overflow_d;
  logic          done_q, done_d;
  logic [3:0]    sel_y;
  logic          run;
  logic          last;
`ifdef ZERO_FLAG_EN
  logic          zero_q, zero_d;
`endif

  assign run  = (state_q == S_RUN);
  assign last = (idx_q == IW'(NIBBLES - 1));

  // Unit drive: only active in RUN so the gated unit outputs read zero elsewhere
  always_comb begin
    au_opCode  = 2'b00;
    au_A       = 4'h0;
    au_B       = 4'h0;
    au_CarryIN = 1'b0;
    if (run) begin
      au_opCode  = op_q ? 2'b10 : 2'b01;
      au_A       = a_q[4*idx_q +: 4];
      au_B       = b_q[4*idx_q +: 4];
      au_CarryIN = chain_q;
    end
  end

  assign sel_y = op_q ? au_sub_Y : au_add_Y;

  // Next-state: capture on start, fold one nibble per RUN cycle, pulse done
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    chain_d     = chain_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    result_d    = result_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;
    done_d      = 1'b0;
`ifdef ZERO_FLAG_EN
    zero_d      = zero_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a_in;
          b_d     = b_in;
          op_d    = op;
          chain_d = carry_in;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        result_d[4*idx_q +: 4] = sel_y;
        chain_d = au_CarryOUT;
        idx_d   = idx_q + 1'b1;
        if (last) begin
          carry_out_d = au_CarryOUT;
          // Signed overflow from operand/result sign bits; sub flips B's role
          overflow_d  = (op_q ? (a_q[W-1] != b_q[W-1]) : (a_q[W-1] == b_q[W-1]))
                        && (result_d[W-1] != a_q[W-1]);
`ifdef ZERO_FLAG_EN
          zero_d      = (result_d == '0);
`endif
          idx_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (done_q) state_d = S_IDLE;
        else        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, asynchronously cleared
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      chain_q     <= 1'b0;
      op_q        <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      done_q      <= 1'b0;
`ifdef ZERO_FLAG_EN
      zero_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      chain_q     <= chain_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
      done_q      <= done_d;
`ifdef ZERO_FLAG_EN
      zero_q      <= zero_d;
`endif
    end
  end

  assign busy      = run;
  assign done      = done_q;
  assign result    = result_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;
`ifdef ZERO_FLAG_EN
  assign zero      = zero_q;
`endif

endmodule

// File: tb/tb_nibble_serial_alu_ctrl.sv
// Directed bench for nibble_serial_alu_ctrl (NIBBLES=4) with a behavioural
// stand-in for the external 4-bit arithmeticUnit.
module tb_nibble_serial_alu_ctrl;
  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         op = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         carry_in = 1'b0;
  logic         busy, done, carry_out, overflow;
  logic [W-1:0] result;
  logic [1:0]   au_opCode;
  logic [3:0]   au_A, au_B;
  logic         au_CarryIN;
  logic [3:0]   au_add_Y, au_sub_Y;
  logic         au_CarryOUT;
`ifdef ZERO_FLAG_EN
  logic         zero;
`endif

  int ncmp = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  nibble_serial_alu_ctrl #(.NIBBLES(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .a_in(a_in), .b_in(b_in), .carry_in(carry_in),
    .busy(busy), .done(done), .result(result),
    .carry_out(carry_out), .overflow(overflow),
`ifdef ZERO_FLAG_EN
    .zero(zero),
`endif
    .au_opCode(au_opCode), .au_A(au_A), .au_B(au_B), .au_CarryIN(au_CarryIN),
    .au_add_Y(au_add_Y), .au_sub_Y(au_sub_Y), .au_CarryOUT(au_CarryOUT)
  );

  // 4-bit unit model: outputs gated by opCode, bit 4 is carry (add) / borrow (sub)
  logic [4:0] m_sum, m_diff;
  always_comb begin
    m_sum       = {1'b0, au_A} + {1'b0, au_B} + {4'b0, au_CarryIN};
    m_diff      = {1'b0, au_A} - {1'b0, au_B} - {4'b0, au_CarryIN};
    au_add_Y    = (au_opCode == 2'b01) ? m_sum[3:0]  : 4'h0;
    au_sub_Y    = (au_opCode == 2'b10) ? m_diff[3:0] : 4'h0;
    au_CarryOUT = (au_opCode == 2'b01) ? m_sum[4] :
                  (au_opCode == 2'b10) ? m_diff[4] : 1'b0;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One transaction; inject=1 pulses start during RUN and during DONE with
  // different operands, which must have no effect.
  task automatic run_op(input string tag, input logic o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic ci, input logic inject,
                        input logic [W-1:0] er, input logic ec, input logic ev,
                        input logic ez);
    int busy_cnt, done_edge, ndone, idle_op_bad;
    @(negedge clk);
    op = o; a_in = a; b_in = b; carry_in = ci; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    busy_cnt = busy ? 1 : 0;
    done_edge = -1; ndone = 0; idle_op_bad = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (busy) busy_cnt++;
      else if (au_opCode !== 2'b00) idle_op_bad++;
      if (done) begin
        if (done_edge < 0) done_edge = k;
        ndone++;
      end
      if (inject) begin
        if (k == 2 || k == 4) begin
          start = 1'b1; op = ~o; a_in = 16'hAAAA; b_in = 16'h5555; carry_in = ~ci;
        end else begin
          start = 1'b0;
        end
      end
      if (done_edge >= 0 && k >= done_edge + 3) break;
    end
    start = 1'b0;
    chk({tag, ".latency"},  64'(done_edge), 64'd5);
    chk({tag, ".ndone"},    64'(ndone), 64'd1);
    chk({tag, ".busy"},     64'(busy_cnt), 64'd4);
    chk({tag, ".idle_op"},  64'(idle_op_bad), 64'd0);
    chk({tag, ".result"},   64'(result), 64'(er));
    chk({tag, ".carry"},    64'(carry_out), 64'(ec));
    chk({tag, ".overflow"}, 64'(overflow), 64'(ev));
`ifdef ZERO_FLAG_EN
    chk({tag, ".zero"},     64'(zero), 64'(ez));
`else
    if (ez) begin end
`endif
  endtask

  initial begin
    int spurious;
    #12;
    // reset state
    chk("rst.outs", 64'({busy, done, result, carry_out, overflow}), 64'd0);
    chk("rst.au",   64'({au_opCode, au_A, au_B, au_CarryIN}), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    run_op("add1",  1'b0, 16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0);
    run_op("addc",  1'b0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    run_op("addv",  1'b0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    run_op("addcv", 1'b0, 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
    run_op("sub1",  1'b1, 16'h1000, 16'h0001, 1'b0, 1'b0, 16'h0FFF, 1'b0, 1'b0, 1'b0);
    run_op("subb",  1'b1, 16'h0000, 16'h0001, 1'b0, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    run_op("subv",  1'b1, 16'h8000, 16'h0001, 1'b0, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0);
    run_op("subbv", 1'b1, 16'h7FFF, 16'hFFFF, 1'b0, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0);
    run_op("addci", 1'b0, 16'h000F, 16'h0000, 1'b1, 1'b0, 16'h0010, 1'b0, 1'b0, 1'b0);
    run_op("subbi", 1'b1, 16'h0010, 16'h0000, 1'b1, 1'b0, 16'h000F, 1'b0, 1'b0, 1'b0);
    run_op("ignore", 1'b0, 16'h1234, 16'h0FFF, 1'b0, 1'b1, 16'h2233, 1'b0, 1'b0, 1'b0);

    // reset in the 2nd RUN cycle: immediate async clear, no done afterwards
    @(negedge clk);
    op = 1'b0; a_in = 16'h7FFF; b_in = 16'h0001; carry_in = 1'b1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    chk("mid.busy_before", 64'(busy), 64'd1);
    rst_n = 1'b0; #1;
    chk("mid.outs", 64'({busy, done, result, carry_out, overflow}), 64'd0);
    chk("mid.au",   64'({au_opCode, au_A, au_B, au_CarryIN}), 64'd0);
    spurious = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (done || busy) spurious++;
      if (k == 3) rst_n = 1'b1;
    end
    chk("mid.no_done", 64'(spurious), 64'd0);

    run_op("post",  1'b1, 16'h1234, 16'h1234, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
